mem_bank_access_sched: RTL and testbench
========================================

# mem_bank_access_sched

Per-bank access scheduler for the memory island. It sits between the post-route spill stage and the bank access multiplexer. It decides, every cycle, whether each narrow SRAM bank serves its narrow requester or the wide-request splitter. A wide access must own all `WideToNarrowFactor` banks of its group at once. Narrow traffic has priority by default, and a per-group starvation counter guarantees forward progress for wide traffic.

## Interface
- `NumNarrowBanks`, 8: number of narrow banks; power of 2.
- `WideToNarrowFactor`, 4: narrow banks per wide group; power of 2; must divide `NumNarrowBanks`.
- `StarveLimit`, 8: consecutive blocked cycles before a wide request gets priority; must be at least 1.
- `NumWideBanks`, `NumNarrowBanks/WideToNarrowFactor`: derived; do not override.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `narrow_valid_i`, in, `NumNarrowBanks`: narrow request pending on bank i.
- `narrow_ready_o`, out, `NumNarrowBanks`: narrow request on bank i granted this cycle.
- `wide_valid_i`, in, `NumWideBanks`: wide request pending on group g.
- `wide_ready_o`, out, `NumWideBanks`: wide request on group g granted this cycle.
- `bank_sel_wide_o`, out, `NumNarrowBanks`: mux select; 1 means bank i takes the wide split request.
- `wide_prio_o`, out, `NumWideBanks`: group g is in `WIDE_PRIO` (debug/status).

## Operation
- Each group g has:
  - a 2-state FSM, `NARROW_PRIO` and `WIDE_PRIO`;
  - a saturating counter `starve_q`, width `$clog2(StarveLimit+1)`.
- Group g covers banks `g*WideToNarrowFactor` to `g*WideToNarrowFactor+WideToNarrowFactor-1`.
- Grants in `NARROW_PRIO`:
  - `narrow_ready_o[i] = narrow_valid_i[i]`.
  - `wide_ready_o[g] = wide_valid_i[g]` AND no `narrow_valid_i` asserted in the group.
- Grants in `WIDE_PRIO`:
  - `wide_ready_o[g] = wide_valid_i[g]`.
  - `narrow_ready_o` is 0 for every bank in the group.
- `bank_sel_wide_o[i] = wide_ready_o[g]` for every bank in the group. When no wide grant is made, the select is 0.
- Counter update, priority highest first:
  - Wide granted: clear to 0.
  - `wide_valid_i[g]` low: clear to 0.
  - Otherwise: increment, saturating at `StarveLimit`.
- FSM transitions:
  - `NARROW_PRIO` to `WIDE_PRIO` when the next counter value equals `StarveLimit`.
  - `WIDE_PRIO` to `NARROW_PRIO` on a wide grant, or when `wide_valid_i[g]` is low (request withdrawn). The counter clears in both cases.
- Groups are fully independent; there is no cross-group coupling.
- Narrow requesters never stall on a foreign group.
- Static asserts check:
  - `NumNarrowBanks` is a power of 2;
  - `NumNarrowBanks % WideToNarrowFactor == 0`;
  - `StarveLimit >= 1`.

## Timing
- Grant latency is 0: all ready and select outputs are combinational from the valid inputs and the registered state.
- The counter and FSM update on the rising edge of `clk_i`.
- A wide request blocked continuously is granted no later than cycle `StarveLimit` after it first asserts. Cycle 0 is the first valid cycle.
  - During cycles 0 to `StarveLimit-1` it is blocked; the FSM enters `WIDE_PRIO` at the edge ending cycle `StarveLimit-1`.
  - The grant comes in cycle `StarveLimit`.
- Simultaneous narrow and wide valid in `NARROW_PRIO` with the counter below the limit: narrow wins.
- Simultaneous valid in `WIDE_PRIO`: wide wins; the narrow requesters in that group see ready 0 for exactly that cycle.
- Requesters must hold valid until ready (valid/ready rule). A withdrawn wide request simply returns the group to `NARROW_PRIO`.
- Reset behaviour:
  - Reset values: every FSM in `NARROW_PRIO`, every `starve_q` 0, `wide_prio_o` 0.
  - With all valids low, all ready/select outputs are 0.
  - Reset asserted mid-operation forces `NARROW_PRIO` immediately (asynchronous). Grants in that cycle follow the reset state.

## Configuration
- `MEM_SCHED_STATS_EN` defined: adds output `wide_stall_cnt_o`, `NumWideBanks` x 32 bits.
  - Each entry is a saturating count of cycles with `wide_valid_i[g]` high and `wide_ready_o[g]` low.
  - Resets to 0 and saturates at `32'hFFFF_FFFF`.
- Undefined: the port and counters are absent. Grant behaviour is identical in both builds.

## Test plan
All scenarios use 8 banks, factor 4, `StarveLimit` 4.
- Reset check: after reset with all valids 0, every output is 0 and `wide_prio_o` is `2'b00`.
- Idle group: `wide_valid_i = 2'b01`, `narrow_valid_i = 0` → `wide_ready_o = 2'b01` and `bank_sel_wide_o = 8'h0F` in the same cycle; counter stays 0.
- Starvation: `narrow_valid_i[1]` held at 1 and `wide_valid_i[0]` held at 1 from cycle 0.
  - Cycles 0–3: `narrow_ready_o[1] = 1`, `wide_ready_o[0] = 0`.
  - Cycle 4: `wide_ready_o[0] = 1`, `narrow_ready_o[3:0] = 0`, `bank_sel_wide_o[3:0] = 4'hF`.
  - Cycle 5: back in `NARROW_PRIO`.
- Isolation: group 1 in `WIDE_PRIO` with `narrow_valid_i = 8'h0F` → `narrow_ready_o = 8'h0F` (group 0 unaffected).
- Withdrawal: group 0 reaches `WIDE_PRIO`, then `wide_valid_i[0]` drops → next cycle `wide_prio_o[0] = 0` and the counter is 0.
- Async reset: assert `rst_ni` low mid-cycle while in `WIDE_PRIO` → `wide_prio_o` is 0 immediately. With `MEM_SCHED_STATS_EN`, `wide_stall_cnt_o[0]` reads 4 before reset and 0 after.

Source files
------------

// File: rtl/mem_bank_access_sched.sv
// mem_bank_access_sched
// Per-bank access scheduler between the post-route spill stage and the bank
// access multiplexer. For every wide group it decides each cycle whether
// the group's narrow banks serve their narrow requesters or the wide-request
// splitter. A wide access must own every bank of its group at once.
// Narrow traffic wins by default. A per-group starvation counter moves a
// blocked wide request into WIDE_PRIO so that it is guaranteed to progress.
//
// Optional feature macro: MEM_SCHED_STATS_EN
//   When defined, adds wide_stall_cnt_o, a saturating 32-bit count per group
//   of the cycles in which the wide request was valid but not granted.
//   Grant behaviour is the same whether or not the macro is defined.

module mem_bank_access_sched #(
    parameter int NumNarrowBanks     = 8,
    parameter int WideToNarrowFactor = 4,
    parameter int StarveLimit        = 8,
    parameter int NumWideBanks       = NumNarrowBanks / WideToNarrowFactor
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumNarrowBanks-1:0]            narrow_valid_i,
    output logic [NumNarrowBanks-1:0]            narrow_ready_o,
    input  logic [NumWideBanks-1:0]              wide_valid_i,
    output logic [NumWideBanks-1:0]              wide_ready_o,
    output logic [NumNarrowBanks-1:0]            bank_sel_wide_o,
    output logic [NumWideBanks-1:0]              wide_prio_o
`ifdef MEM_SCHED_STATS_EN
    ,
    output logic [NumWideBanks-1:0][31:0]        wide_stall_cnt_o
`endif
);

    localparam int W  = WideToNarrowFactor;
    localparam int CW = $clog2(StarveLimit + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(StarveLimit);

    typedef enum logic {
        NARROW_PRIO = 1'b0,
        WIDE_PRIO   = 1'b1
    } state_e;

    // Elaboration-time parameter sanity checks
    if ((NumNarrowBanks <= 0) || ((NumNarrowBanks & (NumNarrowBanks - 1)) != 0)) begin : gen_chk_pow2
        $error("NumNarrowBanks must be a power of 2");
    end
    if ((WideToNarrowFactor <= 0) || ((NumNarrowBanks % WideToNarrowFactor) != 0)) begin : gen_chk_div
        $error("WideToNarrowFactor must divide NumNarrowBanks");
    end
    if (StarveLimit < 1) begin : gen_chk_limit
        $error("StarveLimit must be at least 1");
    end
    if (NumWideBanks != NumNarrowBanks / WideToNarrowFactor) begin : gen_chk_wide
        $error("NumWideBanks is derived and must not be overridden");
    end

    // One independent scheduler per wide group; groups never interact
    for (genvar gi = 0; gi < NumWideBanks; gi++) begin : gen_group
        state_e          state_q, state_d;
        logic [CW-1:0]   starve_q, starve_d;
        logic            narrow_any;
        logic            wide_gnt;

        // Grant decision and next-state computation for this group
        always_comb begin
            narrow_any = |narrow_valid_i[gi*W +: W];

            if (state_q == WIDE_PRIO) begin
                wide_gnt = wide_valid_i[gi];
            end else begin
                wide_gnt = wide_valid_i[gi] & ~narrow_any;
            end

            // A grant or a withdrawn request ends the starvation episode
            if (wide_gnt) begin
                starve_d = '0;
            end else if (!wide_valid_i[gi]) begin
                starve_d = '0;
            end else if (starve_q == STARVE_MAX) begin
                starve_d = starve_q;
            end else begin
                starve_d = starve_q + CW'(1);
            end

            state_d = state_q;
            case (state_q)
                NARROW_PRIO: begin
                    if (starve_d == STARVE_MAX) begin
                        state_d = WIDE_PRIO;
                    end
                end
                WIDE_PRIO: begin
                    if (wide_gnt || !wide_valid_i[gi]) begin
                        state_d = NARROW_PRIO;
                    end
                end
                default: state_d = NARROW_PRIO;
            endcase
        end

        // Priority FSM and starvation counter
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q  <= NARROW_PRIO;
                starve_q <= '0;
            end else begin
                state_q  <= state_d;
                starve_q <= starve_d;
            end
        end

        assign wide_ready_o[gi]             = wide_gnt;
        assign bank_sel_wide_o[gi*W +: W]   = {W{wide_gnt}};
        assign narrow_ready_o[gi*W +: W]    = (state_q == WIDE_PRIO) ? '0
                                                                     : narrow_valid_i[gi*W +: W];
        assign wide_prio_o[gi]              = (state_q == WIDE_PRIO);

`ifdef MEM_SCHED_STATS_EN
        logic [31:0] stall_cnt_q, stall_cnt_d;

        // Saturating count of cycles the wide requester waited
        always_comb begin
            stall_cnt_d = stall_cnt_q;
            if (wide_valid_i[gi] && !wide_gnt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end

        // Stall statistics register
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stall_cnt_q <= '0;
            end else begin
                stall_cnt_q <= stall_cnt_d;
            end
        end

        assign wide_stall_cnt_o[gi] = stall_cnt_q;
`endif
    end

endmodule

// File: tb/tb_mem_bank_access_sched.sv
// Self-checking bench for mem_bank_access_sched (8 banks, factor 4, limit 4).
// Expected outputs come from a small behavioural model. They are queued when
// stimulus is applied and popped when the outputs are sampled. Directed
// checks cover the scenarios in the block's test plan.

module tb_mem_bank_access_sched;

    localparam int NB = 8;
    localparam int F  = 4;
    localparam int SL = 4;
    localparam int NW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [NB-1:0] narrow_valid_i;
    logic [NB-1:0] narrow_ready_o;
    logic [NW-1:0] wide_valid_i;
    logic [NW-1:0] wide_ready_o;
    logic [NB-1:0] bank_sel_wide_o;
    logic [NW-1:0] wide_prio_o;
`ifdef MEM_SCHED_STATS_EN
    logic [NW-1:0][31:0] wide_stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NB-1:0] nr;
        logic [NW-1:0] wr;
        logic [NB-1:0] sel;
        logic [NW-1:0] prio;
    } exp_t;

    exp_t sb_q[$];
    exp_t last;

    // Reference model state
    int          m_wide[NW];
    int          m_blocked[NW];
    logic [31:0] m_stall[NW];

    mem_bank_access_sched #(
        .NumNarrowBanks    (NB),
        .WideToNarrowFactor(F),
        .StarveLimit       (SL)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .narrow_valid_i  (narrow_valid_i),
        .narrow_ready_o  (narrow_ready_o),
        .wide_valid_i    (wide_valid_i),
        .wide_ready_o    (wide_ready_o),
        .bank_sel_wide_o (bank_sel_wide_o),
        .wide_prio_o     (wide_prio_o)
`ifdef MEM_SCHED_STATS_EN
        ,
        .wide_stall_cnt_o(wide_stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < NW; g++) begin
            m_wide[g]    = 0;
            m_blocked[g] = 0;
            m_stall[g]   = 32'd0;
        end
    endtask

    function automatic exp_t model_out(input logic [NB-1:0] nv, input logic [NW-1:0] wv);
        exp_t e;
        e.nr = '0; e.wr = '0; e.sel = '0; e.prio = '0;
        for (int g = 0; g < NW; g++) begin
            logic [F-1:0] slice;
            slice = nv[g*F +: F];
            e.prio[g] = (m_wide[g] != 0);
            if (m_wide[g] != 0) begin
                e.wr[g] = wv[g];
            end else begin
                e.wr[g] = wv[g] && (slice == '0);
                e.nr[g*F +: F] = slice;
            end
            e.sel[g*F +: F] = {F{e.wr[g]}};
        end
        return e;
    endfunction

    // Advance the model across one rising edge
    task automatic model_update(input logic [NW-1:0] wv, input logic [NW-1:0] wr);
        for (int g = 0; g < NW; g++) begin
            if (wv[g] && !wr[g] && m_stall[g] != 32'hFFFF_FFFF) m_stall[g] = m_stall[g] + 32'd1;
            if (wr[g] || !wv[g]) begin
                m_blocked[g] = 0;
                m_wide[g]    = 0;
            end else begin
                if (m_blocked[g] < SL) m_blocked[g]++;
                if (m_blocked[g] == SL) m_wide[g] = 1;
            end
        end
    endtask

    // One cycle: drive at negedge, queue expectation, sample 2 ns later
    task automatic step(input logic [NB-1:0] nv, input logic [NW-1:0] wv, input string tag);
        exp_t e;
        @(negedge clk_i);
        narrow_valid_i = nv;
        wide_valid_i   = wv;
        sb_q.push_back(model_out(nv, wv));
        #2;
        e = sb_q.pop_front();
        last = e;
        check_val({tag, ".nr"},   32'(narrow_ready_o),  32'(e.nr));
        check_val({tag, ".wr"},   32'(wide_ready_o),    32'(e.wr));
        check_val({tag, ".sel"},  32'(bank_sel_wide_o), 32'(e.sel));
        check_val({tag, ".prio"}, 32'(wide_prio_o),     32'(e.prio));
`ifdef MEM_SCHED_STATS_EN
        for (int g = 0; g < NW; g++)
            check_val($sformatf("%s.stall%0d", tag, g), wide_stall_cnt_o[g], m_stall[g]);
`endif
        model_update(wv, e.wr);
    endtask

    initial begin
        rst_ni = 1'b0;
        narrow_valid_i = '0;
        wide_valid_i   = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        check_val("rst.nr",   32'(narrow_ready_o),  32'h0);
        check_val("rst.wr",   32'(wide_ready_o),    32'h0);
        check_val("rst.sel",  32'(bank_sel_wide_o), 32'h0);
        check_val("rst.prio", 32'(wide_prio_o),     32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(8'h00, 2'b00, "idle0");

        // Idle group: wide grant in the same cycle, counter stays 0
        step(8'h00, 2'b01, "idlegrp");
        check_val("idlegrp.wr_c",  32'(wide_ready_o),    32'h1);
        check_val("idlegrp.sel_c", 32'(bank_sel_wide_o), 32'h0F);
        step(8'h00, 2'b00, "idlegrp_after");
        check_val("idlegrp.cnt", 32'(dut.gen_group[0].starve_q), 32'h0);

        // Starvation of group 0 by narrow bank 1
        for (int c = 0; c < 6; c++) begin
            step(8'h02, 2'b01, $sformatf("starve_c%0d", c));
            if (c < SL) begin
                check_val($sformatf("starve_c%0d.nr1", c), 32'(narrow_ready_o[1]), 32'h1);
                check_val($sformatf("starve_c%0d.wr0", c), 32'(wide_ready_o[0]),   32'h0);
            end else if (c == SL) begin
                check_val("starve_c4.wr0",  32'(wide_ready_o[0]),       32'h1);
                check_val("starve_c4.nr",   32'(narrow_ready_o[3:0]),   32'h0);
                check_val("starve_c4.sel",  32'(bank_sel_wide_o[3:0]),  32'hF);
            end else begin
                check_val("starve_c5.prio", 32'(wide_prio_o[0]), 32'h0);
            end
        end
        step(8'h00, 2'b00, "starve_idle");

        // Isolation: group 1 in WIDE_PRIO leaves group 0 narrow traffic alone
        repeat (SL) step(8'h10, 2'b10, "iso_pre");
        step(8'h0F, 2'b10, "iso");
        check_val("iso.nr_c",   32'(narrow_ready_o), 32'h0F);
        check_val("iso.prio_c", 32'(wide_prio_o),    32'h2);
        check_val("iso.sel_c",  32'(bank_sel_wide_o), 32'hF0);
        step(8'h00, 2'b00, "iso_idle");

        // Withdrawal from WIDE_PRIO
        repeat (SL) step(8'h02, 2'b01, "wd_pre");
        step(8'h02, 2'b00, "wd");
        check_val("wd.prio_c", 32'(wide_prio_o[0]), 32'h1);
        step(8'h00, 2'b00, "wd_after");
        check_val("wd_after.prio_c", 32'(wide_prio_o[0]), 32'h0);
        check_val("wd_after.cnt",    32'(dut.gen_group[0].starve_q), 32'h0);

        // Mixed random traffic checked against the model
        for (int i = 0; i < 200; i++) begin
            logic [NB-1:0] nv;
            logic [NW-1:0] wv;
            nv = NB'($urandom) & NB'($urandom);
            wv = NW'($urandom);
            step(nv, wv, $sformatf("rnd%0d", i));
        end

        // Fresh reset, then asynchronous reset while in WIDE_PRIO
        @(negedge clk_i);
        narrow_valid_i = '0;
        wide_valid_i   = '0;
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        model_reset();
        repeat (SL) step(8'h02, 2'b01, "ar_pre");
        @(negedge clk_i);
        #1;
        check_val("ar.prio_before", 32'(wide_prio_o), 32'h1);
`ifdef MEM_SCHED_STATS_EN
        check_val("ar.stall_before", wide_stall_cnt_o[0], 32'd4);
`endif
        rst_ni = 1'b0;
        #1;
        check_val("ar.prio_after", 32'(wide_prio_o),     32'h0);
        check_val("ar.wr_after",   32'(wide_ready_o),    32'h0);
        check_val("ar.nr_after",   32'(narrow_ready_o),  32'h02);
        check_val("ar.sel_after",  32'(bank_sel_wide_o), 32'h0);
`ifdef MEM_SCHED_STATS_EN
        check_val("ar.stall_after", wide_stall_cnt_o[0], 32'd0);
`endif
        @(negedge clk_i);
        narrow_valid_i = '0;
        wide_valid_i   = '0;
        rst_ni = 1'b1;
        model_reset();
        step(8'h00, 2'b01, "post_rst");

        check_val("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
